// File: rtl/present_pkg.sv
// Shared types, constants and round functions for the PRESENT-80 encryption core.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int ROUNDS  = 31;
  localparam int CNT_W   = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } core_state_t;

  // 4-bit substitution table, indexed by the input nibble
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Apply the S-box to every nibble of the 64-bit state
  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] din);
    logic [BLOCK_W-1:0] dout;
    dout = '0;
    for (int n = 0; n < 16; n++) begin
      dout[4*n +: 4] = SBOX[din[4*n +: 4]];
    end
    return dout;
  endfunction

  // Bit permutation: bit i moves to (16*i) mod 63, bit 63 stays in place
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] din);
    logic [BLOCK_W-1:0] dout;
    dout = '0;
    for (int i = 0; i < 63; i++) begin
      dout[(16 * i) % 63] = din[i];
    end
    dout[63] = din[63];
    return dout;
  endfunction

  // One step of the 80-bit key schedule: rotate left 61, S-box the top nibble,
  // fold the round counter into bits 19..15
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] key,
                                                  input logic [CNT_W-1:0] rc);
    logic [KEY_W-1:0] k;
    k          = {key[18:0], key[79:19]};
    k[79:76]   = SBOX[k[79:76]];
    k[19:15]   = k[19:15] ^ rc;
    return k;
  endfunction

endpackage

// File: rtl/present_key_schedule.sv
// Working round-key register and round counter for the PRESENT-80 core.
// rk_next is the key for the following round, also used for final whitening.
module present_key_schedule
  import present_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start,
  input  logic             advance,
  input  logic [KEY_W-1:0] master_key,
  output logic [KEY_W-1:0] rk,
  output logic [KEY_W-1:0] rk_next,
  output logic [CNT_W-1:0] cnt
);

  assign rk_next = key_update(rk, cnt);

  // Seed from the master key on start, otherwise step once per active round
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rk  <= '0;
      cnt <= '0;
    end else if (start) begin
      rk  <= master_key;
      cnt <= CNT_W'(1);
    end else if (advance) begin
      rk  <= rk_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/present80_encryptor.sv
// Iterative PRESENT-80 encryption core: one round per clock, 31 rounds,
// ciphertext registered on data_o and held until the next completion.
module present80_encryptor
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [KEY_W-1:0]   data_i,
  input  logic               key_load,
  input  logic               data_load,
  output logic [BLOCK_W-1:0] data_o
);

  logic [KEY_W-1:0]   master_key;
  logic [KEY_W-1:0]   rk;
  logic [KEY_W-1:0]   rk_next;
  logic [CNT_W-1:0]   cnt;
  logic [BLOCK_W-1:0] state;
  logic [BLOCK_W-1:0] round_out;
  core_state_t        core_state;
  logic               start;
  logic               busy;
  logic               last_round;

  // A key load in the same cycle suppresses the data load
  assign start      = data_load & ~key_load;
  assign busy       = (core_state == ST_BUSY);
  assign round_out  = p_layer(sbox_layer(state ^ rk[79:16]));
  assign last_round = busy && (cnt == CNT_W'(ROUNDS));

  present_key_schedule u_key_schedule (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start      (start),
    .advance    (busy),
    .master_key (master_key),
    .rk         (rk),
    .rk_next    (rk_next),
    .cnt        (cnt)
  );

  // Master key register; an in-flight encryption keeps using its own rk copy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      master_key <= '0;
    end else if (key_load) begin
      master_key <= data_i;
    end
  end

  // Round state machine: start or restart on a load, iterate while busy,
  // whiten with K32 and publish the ciphertext on the last round
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_state <= ST_IDLE;
      state      <= '0;
      data_o     <= '0;
    end else if (start) begin
      core_state <= ST_BUSY;
      state      <= data_i[BLOCK_W-1:0];
    end else if (busy) begin
      state <= round_out;
      if (last_round) begin
        data_o     <= round_out ^ rk_next[79:16];
        core_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_present80_encryptor.sv
// Directed bench for the PRESENT-80 core: table of known-answer vectors plus
// hand-written sequences for key reload, strobe collision, restart and reset.
module tb_present80_encryptor;

  logic        clk_i;
  logic        rst_ni;
  logic [79:0] data_i;
  logic        key_load;
  logic        data_load;
  logic [63:0] data_o;

  int vec_count;
  int miscompares;
  logic [63:0] last_ct;

  localparam logic [79:0] KEY_ZERO = 80'h0;
  localparam logic [79:0] KEY_ONES = {80{1'b1}};
  localparam logic [63:0] PT_ZERO  = 64'h0;
  localparam logic [63:0] PT_ONES  = {64{1'b1}};

  typedef struct {
    string       name;
    logic [79:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
  } vec_t;

  vec_t vectors [4];

  present80_encryptor dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .data_i    (data_i),
    .key_load  (key_load),
    .data_load (data_load),
    .data_o    (data_o)
  );

  // Free-running 10 ns clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one rising edge, leaving 1 ns for outputs to settle
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] expected);
    vec_count++;
    if (data_o !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: data_o=%h expected=%h", name, data_o, expected);
    end
  endtask

  task automatic loadKey(input logic [79:0] key);
    data_i   = key;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic startOnly(input logic [63:0] pt);
    data_i    = {16'hA5A5, pt};
    data_load = 1'b1;
    tick();
    data_load = 1'b0;
  endtask

  // Load key, then plaintext; returns right after the data_load edge
  task automatic applyStimulus(input logic [79:0] key, input logic [63:0] pt);
    loadKey(key);
    startOnly(pt);
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    last_ct     = '0;
    rst_ni      = 1'b0;
    data_i      = '0;
    key_load    = 1'b0;
    data_load   = 1'b0;

    vectors[0] = '{"k0_p0",       KEY_ZERO, PT_ZERO, 64'h5579C1387B228445};
    vectors[1] = '{"k1_p0",       KEY_ONES, PT_ZERO, 64'hE72C46C0F5945049};
    vectors[2] = '{"k0_p1",       KEY_ZERO, PT_ONES, 64'hA112FFC72F68417B};
    vectors[3] = '{"k1_p1",       KEY_ONES, PT_ONES, 64'h3333DCD3213210D2};

    repeat (3) tick();
    checkOutput("reset_value", 64'h0);
    rst_ni = 1'b1;
    tick();

    // Known-answer vectors: output must hold for 30 edges, update on the 31st
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vectors[v].key, vectors[v].pt);
      repeat (30) tick();
      checkOutput({vectors[v].name, "_hold"}, last_ct);
      tick();
      checkOutput(vectors[v].name, vectors[v].ct);
      last_ct = vectors[v].ct;
    end

    // New master key mid-encryption must not disturb the running operation
    applyStimulus(KEY_ZERO, PT_ONES);
    repeat (10) tick();
    loadKey(KEY_ONES);
    repeat (9) tick();
    checkOutput("midkey_hold20", last_ct);
    repeat (10) tick();
    checkOutput("midkey_hold30", last_ct);
    tick();
    checkOutput("midkey_result", 64'hA112FFC72F68417B);
    last_ct = 64'hA112FFC72F68417B;
    startOnly(PT_ZERO);
    repeat (31) tick();
    checkOutput("midkey_newkey", 64'hE72C46C0F5945049);
    last_ct = 64'hE72C46C0F5945049;

    // key_load and data_load together: key updates, no encryption starts
    data_i    = KEY_ZERO;
    key_load  = 1'b1;
    data_load = 1'b1;
    tick();
    key_load  = 1'b0;
    data_load = 1'b0;
    repeat (35) tick();
    checkOutput("collide_no_start", last_ct);
    startOnly(PT_ZERO);
    repeat (31) tick();
    checkOutput("collide_key_taken", 64'h5579C1387B228445);
    last_ct = 64'h5579C1387B228445;

    // data_load while busy restarts with the new plaintext
    loadKey(KEY_ONES);
    startOnly(PT_ZERO);
    repeat (5) tick();
    startOnly(PT_ONES);
    repeat (25) tick();
    checkOutput("restart_no_early", last_ct);
    repeat (5) tick();
    checkOutput("restart_hold30", last_ct);
    tick();
    checkOutput("restart_result", 64'h3333DCD3213210D2);
    last_ct = 64'h3333DCD3213210D2;

    // Asynchronous reset at round 10 clears output at once and aborts the run
    applyStimulus(KEY_ZERO, PT_ZERO);
    repeat (10) tick();
    rst_ni = 1'b0;
    #1;
    checkOutput("async_reset", 64'h0);
    last_ct = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    repeat (35) tick();
    checkOutput("reset_aborted", 64'h0);
    applyStimulus(KEY_ONES, PT_ONES);
    repeat (30) tick();
    checkOutput("post_reset_hold", 64'h0);
    tick();
    checkOutput("post_reset_result", 64'h3333DCD3213210D2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
